// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Multiply-accumulate back end. Consumes a stream of unsigned 2N-bit
//   products over a valid/ready handshake and sums a programmed number of
//   them into an ACC_W = 2N+G bit accumulator. The total is then held on an
//   output valid/ready handshake until the consumer takes it.
//
//   Build option: MAC_SAT_EN
//     defined   : on carry out the accumulator clamps to all-ones and stays there
//     undefined : the accumulator wraps modulo 2^ACC_W
//   In both builds `overflow` is a sticky per-run flag set on any carry out.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle pulse starting a run (honoured only in IDLE)
//   len        number of products to accumulate, captured with start
//   in_valid   product on prod is valid
//   in_ready   block accepts a product this cycle (ACCUM state)
//   prod       unsigned 2N-bit product
//   out_valid  acc_out/overflow hold a finished result (DONE state)
//   out_ready  consumer takes the result
//   acc_out    accumulated sum
//   overflow   sticky carry-out flag for the current run
//   busy       high whenever the block is not IDLE
module mac_accumulator #(
    parameter int unsigned N     = 8,
    parameter int unsigned G     = 4,
    parameter int unsigned ACC_W = 2*N + G
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    // One extra bit captures the carry out of the top accumulator bit.
    logic [ACC_W:0]   sum_w;
    logic             carry_w;
    logic [ACC_W-1:0] acc_nxt_w;

    assign sum_w   = {1'b0, acc_q} + {{(ACC_W + 1 - 2*N){1'b0}}, prod};
    assign carry_w = sum_w[ACC_W];

`ifdef MAC_SAT_EN
    // Once clamped at all-ones, any further nonzero product carries again,
    // and a zero product leaves all-ones unchanged, so the clamp holds.
    assign acc_nxt_w = carry_w ? '1 : sum_w[ACC_W-1:0];
`else
    assign acc_nxt_w = sum_w[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == 8'd0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                // in_ready is implied by the state, so in_valid alone marks a transfer.
                if (in_valid) begin
                    acc_d = acc_nxt_w;
                    ovf_d = ovf_q | carry_w;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Testbench for mac_accumulator (N=8, G=4, ACC_W=20). Directed runs push
// their expected result into a queue; a monitor compares the presented
// result every cycle out_valid is high and pops it on the handshake.
module tb_mac_accumulator;

    localparam int unsigned N     = 8;
    localparam int unsigned G     = 4;
    localparam int unsigned ACC_W = 2*N + G;

    logic             clk;
    logic             rst;
    logic             start;
    logic [7:0]       len;
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             busy;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic             ovf;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mac_accumulator #(.N(N), .G(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare on every cycle a result is presented,
    // which also checks the result is held stable under backpressure.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                chk({exp_q[0].name, "_acc"}, 32'(acc_out), 32'(exp_q[0].acc));
                chk({exp_q[0].name, "_ovf"}, 32'(overflow), 32'(exp_q[0].ovf));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input string name, input logic [ACC_W-1:0] a, input logic o);
        exp_t e;
        e.acc  = a;
        e.ovf  = o;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 8'd0;
    endtask

    // Presents p with in_valid high until accepted; leaves in_valid high.
    task automatic send(input logic [2*N-1:0] p);
        bit ok = 1'b0;
        in_valid = 1'b1;
        prod     = p;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        prod      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_acc",       32'(acc_out),   32'd0);
        rst = 1'b0;
        tick();

        // Basic back-to-back run: 6+10+255
        expect_result("basic", 20'd271, 1'b0);
        do_start(8'd3);
        chk("basic_start_in_ready", 32'(in_ready), 32'd1);
        chk("basic_start_busy",     32'(busy),     32'd1);
        send(16'd6);
        send(16'd10);
        send(16'd255);
        in_valid = 1'b0;
        chk("basic_out_valid_lat", 32'(out_valid), 32'd1);
        chk("basic_in_ready_done", 32'(in_ready),  32'd0);
        wait_idle();

        // Input stall between products, then output backpressure
        out_ready = 1'b0;
        expect_result("stall", 20'd300, 1'b0);
        do_start(8'd2);
        send(16'd100);
        in_valid = 1'b0;
        prod     = 16'hFFFF;
        repeat (3) tick();
        send(16'd200);
        in_valid = 1'b0;
        chk("stall_out_valid_lat", 32'(out_valid), 32'd1);
        repeat (5) tick();
        chk("bp_out_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_idle();

        // Zero length: result next cycle, no product accepted
        out_ready = 1'b0;
        expect_result("zero", 20'd0, 1'b0);
        in_valid = 1'b1;
        prod     = 16'd55;
        do_start(8'd0);
        chk("zero_out_valid", 32'(out_valid), 32'd1);
        chk("zero_in_ready",  32'(in_ready),  32'd0);
        tick();
        chk("zero_in_ready2", 32'(in_ready),  32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // 16 x 65025 = 1040400 fits in 20 bits
        expect_result("len16", 20'd1040400, 1'b0);
        do_start(8'd16);
        for (int i = 0; i < 16; i++) send(16'd65025);
        in_valid = 1'b0;
        wait_idle();

        // 17 x 65025 = 1105425 overflows 2^20
`ifdef MAC_SAT_EN
        expect_result("len17", 20'd1048575, 1'b1);
`else
        expect_result("len17", 20'd56849, 1'b1);
`endif
        do_start(8'd17);
        for (int i = 0; i < 17; i++) send(16'd65025);
        in_valid = 1'b0;
        wait_idle();

        // Reset mid-run after 2 of 5 products
        do_start(8'd5);
        send(16'd40);
        send(16'd50);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_overflow",  32'(overflow),  32'd0);
        chk("midrst_acc",       32'(acc_out),   32'd0);
        rst = 1'b0;
        tick();
        expect_result("after_rst", 20'd7, 1'b0);
        do_start(8'd1);
        send(16'd7);
        in_valid = 1'b0;
        wait_idle();

        // start pulsed during ACCUM is ignored
        expect_result("ign_start", 20'd6, 1'b0);
        do_start(8'd3);
        send(16'd1);
        in_valid = 1'b0;
        start = 1'b1;
        len   = 8'd9;
        tick();
        start = 1'b0;
        len   = 8'd0;
        chk("ign_start_busy", 32'(in_ready), 32'd1);
        send(16'd2);
        send(16'd3);
        in_valid = 1'b0;
        chk("ign_start_done", 32'(out_valid), 32'd1);
        wait_idle();

        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential multiply-accumulate back end that sits directly downstream of `multiplier_array`. It consumes a stream of unsigned 2N-bit products over a valid/ready handshake and sums a programmed number of them into a widened accumulator. It then presents the total on a held output handshake. It is the accumulation stage of the dot-product datapath: the array multiplier feeds it, and the result consumer drains it.

## Interface
- `N`, default 8, multiplier operand width; product width is 2N.
- `G`, default 4, accumulator guard bits; ACC_W = 2N+G.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle pulse; begins a new accumulation. Sampled only in IDLE.
- `len`  input  8  number of products to accumulate; sampled with `start`.
- `in_valid`  input  1  product on `prod` is valid.
- `in_ready`  output  1  block accepts a product this cycle.
- `prod`  input  2N  unsigned product; connects directly to `multiplier_array.P`.
- `out_valid`  output  1  `acc_out` holds a finished result.
- `out_ready`  input  1  consumer takes the result.
- `acc_out`  output  ACC_W  accumulated sum, zero-extended products.
- `overflow`  output  1  sticky flag: some addition exceeded 2^ACC_W − 1 during this run.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On `start`: load `len` into the remaining counter, clear `acc_out` and `overflow`.
  - Go to ACCUM if `len` != 0.
  - Go to DONE if `len` == 0; the result is 0.
- ACCUM:
  - `in_ready`=1.
  - A transfer occurs when `in_valid` & `in_ready`. On a transfer, acc <= acc + zero_ext(prod) and the counter decrements.
  - When the counter goes 1→0 on a transfer, go to DONE.
  - `in_valid` low: hold all state; no bubble penalty.
- DONE:
  - `out_valid`=1, `in_ready`=0.
  - `acc_out` and `overflow` are stable until `out_ready`.
  - Go to IDLE on `out_valid` & `out_ready`.
- `start` outside IDLE is ignored; no restart and no effect on `len` in flight.
- Arithmetic: unsigned, ACC_W-bit sum. Overflow is detected as carry out of bit ACC_W−1. Overflow handling is selected per Configuration.
- Reset mid-operation (any state): return to IDLE next edge and abandon the partial sum.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `busy`=0, `overflow`=0.
  - `acc_out`=0; state IDLE; counter 0.
- `start` at edge k gives ACCUM (`in_ready`=1, `busy`=1) from cycle k+1.
- Throughput: one product per cycle in ACCUM.
- Last product accepted at edge m gives `out_valid`=1 in cycle m+1, carrying the full sum including that product.
- `len`=0: `start` at edge k gives `out_valid`=1 in cycle k+1 with `acc_out`=0.
- `out_ready` may be high before `out_valid`. The handshake completes on the first cycle both are high. IDLE follows, and `start` is accepted the cycle after.
- `in_ready` is a function of state only; it never depends combinationally on `in_valid`.
- `out_valid` is registered state, with no combinational path from `out_ready`.

## Configuration
- Macro `MAC_SAT_EN`.
- Defined: on overflow, the accumulator clamps to 2^ACC_W − 1 and stays clamped for the rest of the run. `overflow` is set.
- Undefined: the accumulator wraps modulo 2^ACC_W. `overflow` is still set, sticky, on any carry out.
- Handshake, timing and state machine are identical in both builds.

## Test plan
All scenarios use N=8, G=4, ACC_W=20.
- Basic run: `start`, `len`=3, products 6, 10, 255 back-to-back → `out_valid` one cycle after the third transfer, `acc_out`=271, `overflow`=0.
- Stalls and backpressure:
  - `len`=2, products 100 and 200, with `in_valid` low for 3 cycles between them → `acc_out`=300.
  - Hold `out_ready`=0 for 5 cycles → `acc_out` stays stable and `out_valid` stays high until release.
- Zero length: `start` with `len`=0 → `out_valid` next cycle, `acc_out`=0, no product accepted (`in_ready` never 1).
- Overflow: `len`=17, all products 65025.
  - With `MAC_SAT_EN`: `acc_out`=1048575, `overflow`=1.
  - Without `MAC_SAT_EN`: `acc_out`=56849, `overflow`=1.
  - With `len`=16, both builds give `acc_out`=1040400, `overflow`=0.
- Reset and ignored start:
  - Assert `rst` after 2 of 5 products → all outputs return to reset values next cycle. A following run with `len`=1 and product 7 gives `acc_out`=7.
  - `start` with `len`=9 pulsed during ACCUM → ignored; the original count completes.
